// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and arbitrate the nine board-cell buttons into one-hot accepted presses.
// Define BTN_LEVEL_OUT_EN to hold the accepted cell's bit high for the whole HELD period instead of pulsing it.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int RAW_ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] btn_raw,
    output logic [8:0] cell_pulse,
    output logic       busy,
    output logic       chord_err
);
    typedef enum logic {IDLE, HELD} state_t;
    state_t state_q, state_d;
    logic [8:0] raw_n, sync1_q, sync2_q, db_q, db_d, db_dly_q, pe;
    logic [8:0] pulse_q, pulse_d;
    logic chord_q, chord_d;
    logic [CNT_W-1:0] cnt_q [9];
    logic [CNT_W-1:0] cnt_d [9];
    logic one_hot;
    assign raw_n = (RAW_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
    assign pe = db_q & ~db_dly_q;
    assign one_hot = (pe != 9'd0) && ((pe & (pe - 9'd1)) == 9'd0);
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            cnt_d[k] = '0;
            db_d[k] = db_q[k];
            if (sync2_q[k] != db_q[k]) begin
                if (cnt_q[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) db_d[k] = sync2_q[k];
                else cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        pulse_d = '0;
        chord_d = 1'b0;
        if (state_q == IDLE) begin
            if (pe != 9'd0) begin
                state_d = HELD;
                pulse_d = one_hot ? pe : 9'd0;
                chord_d = ~one_hot;
            end
        end else begin
            if (db_q == 9'd0) state_d = IDLE;
`ifdef BTN_LEVEL_OUT_EN
            pulse_d = (db_q == 9'd0) ? 9'd0 : pulse_q;
`endif
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            for (int k = 0; k < 9; k++) cnt_q[k] <= '0;
            state_q  <= IDLE;
            pulse_q  <= '0;
            chord_q  <= 1'b0;
        end else begin
            sync1_q  <= raw_n;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            for (int k = 0; k < 9; k++) cnt_q[k] <= cnt_d[k];
            state_q  <= state_d;
            pulse_q  <= pulse_d;
            chord_q  <= chord_d;
        end
    end
    assign cell_pulse = pulse_q;
    assign chord_err  = chord_q;
    assign busy       = (state_q == HELD);
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench; each press pushes its expected output event, the monitor pops and compares.
module tb_button_conditioner;
    logic clk = 1'b0, reset = 1'b1;
    logic [8:0] btn_raw = 9'h1FF;
    logic [8:0] cell_pulse;
    logic busy, chord_err;
    int checks = 0, failures = 0, cyc = 0;
    logic [8:0] prev_pulse = '0;
`ifdef BTN_LEVEL_OUT_EN
    localparam bit LVL = 1'b1;
`else
    localparam bit LVL = 1'b0;
`endif
    typedef struct {int cyc; logic [8:0] pulse; logic chord;} ev_t;
    ev_t q[$];

    button_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .RAW_ACTIVE_LOW(1)) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .cell_pulse(cell_pulse), .busy(busy), .chord_err(chord_err));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int dly, input logic [8:0] p, input logic c);
        ev_t e;
        e.cyc = cyc + dly;
        e.pulse = p;
        e.chord = c;
        q.push_back(e);
    endtask

    // A new event is a chord flag or a change to a nonzero pulse (a level-mode hold is one event).
    always @(negedge clk) begin
        if (!reset && (chord_err || (cell_pulse != 9'd0 && cell_pulse != prev_pulse))) begin
            if (q.size() == 0) chk("spurious", {22'd0, cell_pulse, chord_err}, 32'd0);
            else begin
                ev_t e;
                e = q.pop_front();
                chk("when", cyc, e.cyc);
                chk("cell", cell_pulse, e.pulse);
                chk("chord", chord_err, e.chord);
            end
        end
        prev_pulse <= cell_pulse;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tick(2);
        chk("rst_pulse", cell_pulse, 9'd0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        // idle, all released
        tick(20);
        chk("idle_busy", busy, 1'b0);
        chk("idle_pulse", cell_pulse, 9'd0);
        chk("idle_chord", chord_err, 1'b0);
        // single press of e
        btn_raw[4] = 1'b0;
        expect_ev(7, 9'h010, 1'b0);
        tick(6);
        chk("e_busy_pre", busy, 1'b0);
        tick(1);
        chk("e_busy", busy, 1'b1);
        tick(1);
        chk("e_after", cell_pulse, LVL ? 9'h010 : 9'h000);
        tick(22);
        btn_raw = 9'h1FF;
        tick(6);
        chk("e_rel_busy", busy, 1'b1);
        chk("e_rel_pulse", cell_pulse, LVL ? 9'h010 : 9'h000);
        tick(1);
        chk("e_idle_busy", busy, 1'b0);
        chk("e_idle_pulse", cell_pulse, 9'd0);
        tick(5);
        // 3-cycle glitch on a
        btn_raw[0] = 1'b0;
        tick(3);
        btn_raw = 9'h1FF;
        tick(12);
        chk("glitch_busy", busy, 1'b0);
        // chord c+g
        btn_raw[2] = 1'b0;
        btn_raw[6] = 1'b0;
        expect_ev(7, 9'h000, 1'b1);
        tick(7);
        chk("chord_busy", busy, 1'b1);
        chk("chord_pulse", cell_pulse, 9'd0);
        tick(1);
        chk("chord_once", chord_err, 1'b0);
        tick(12);
        btn_raw = 9'h1FF;
        tick(6);
        chk("chord_rel_busy", busy, 1'b1);
        tick(1);
        chk("chord_idle", busy, 1'b0);
        tick(5);
        // b held, then i; release b first
        btn_raw[1] = 1'b0;
        expect_ev(7, 9'h002, 1'b0);
        tick(10);
        btn_raw[8] = 1'b0;
        tick(10);
        btn_raw[1] = 1'b1;
        tick(15);
        chk("bi_busy_hold", busy, 1'b1);
        btn_raw[8] = 1'b1;
        tick(6);
        chk("bi_busy_rel", busy, 1'b1);
        tick(1);
        chk("bi_idle", busy, 1'b0);
        tick(5);
        // d held through reset
        btn_raw[3] = 1'b0;
        expect_ev(7, 9'h008, 1'b0);
        tick(12);
        chk("d_busy", busy, 1'b1);
        reset = 1'b1;
        tick(1);
        chk("d_rst_busy", busy, 1'b0);
        chk("d_rst_pulse", cell_pulse, 9'd0);
        chk("d_rst_chord", chord_err, 1'b0);
        tick(1);
        reset = 1'b0;
        expect_ev(7, 9'h008, 1'b0);
        tick(6);
        chk("d_busy_pre", busy, 1'b0);
        tick(1);
        chk("d_busy2", busy, 1'b1);
        tick(3);
        chk("d_level", cell_pulse, LVL ? 9'h008 : 9'h000);
        btn_raw = 9'h1FF;
        tick(7);
        chk("d_idle", busy, 1'b0);
        chk("d_idle_pulse", cell_pulse, 9'd0);
        tick(5);
        // reset mid-debounce of f: no pulse
        btn_raw[5] = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(1);
        btn_raw = 9'h1FF;
        tick(1);
        reset = 1'b0;
        tick(15);
        chk("f_busy", busy, 1'b0);
        chk("pending", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
